// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared types and helpers for the core shared memory model
package core_mem_pkg;

    localparam int MAX_PORTS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/core_mem_rr_arbiter.sv
// rtl/core_mem_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module core_mem_rr_arbiter
    import core_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     idx
);

    logic             found;
    logic [PTR_W-1:0] p;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p = PTR_W'((int'(ptr) + i) % NUM_PORTS);
            if (!found && req[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                idx      = p;
            end
        end
    end

endmodule

// File: rtl/core_shared_mem.sv
// rtl/core_shared_mem.sv - multi-port shared word RAM with round-robin grant and wait states
module core_shared_mem
    import core_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4096,
    parameter int BASE_WAIT = 1
) (
    input  logic                          CCLK,
    input  logic                          CRST,
    input  logic [NUM_PORTS-1:0]          REQ,
    input  logic [NUM_PORTS-1:0]          WE,
    input  logic [NUM_PORTS*ADDR_W-1:0]   ADDR,
    input  logic [NUM_PORTS*DATA_W-1:0]   WDATA,
    input  logic [NUM_PORTS*DATA_W/8-1:0] WSTRB,
    input  logic [3:0]                    EXTRA_WAIT,
    output logic [DATA_W-1:0]             RDATA,
    output logic [NUM_PORTS-1:0]          VALID,
    output logic                          BUSY,
    input  logic                          LOAD_EN,
    input  logic [idx_w(DEPTH)-1:0]       LOAD_ADDR,
    input  logic [DATA_W-1:0]             LOAD_DATA
);

    localparam int IDX_W  = idx_w(DEPTH);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_W-1:0]    mem [DEPTH];

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [4:0]           cnt;
    logic [NUM_PORTS-1:0] cap_grant;
    logic [PTR_W-1:0]     cap_port;
    logic                 cap_we;
    logic [IDX_W-1:0]     cap_idx;
    logic [DATA_W-1:0]    cap_wdata;
    logic [STRB_W-1:0]    cap_wstrb;

    logic [NUM_PORTS-1:0] arb_grant;
    logic [PTR_W-1:0]     arb_idx;

    logic [NUM_PORTS-1:0] t_grant;
    logic [PTR_W-1:0]     t_port;
    logic                 t_we;
    logic [IDX_W-1:0]     t_idx;
    logic [DATA_W-1:0]    t_wdata;
    logic [STRB_W-1:0]    t_wstrb;
    logic [DATA_W-1:0]    word;
    logic [4:0]           wait_load;
    logic [PTR_W-1:0]     ptr_next;
    logic                 go_resp;
    logic                 load_ok;
    logic                 unused_addr;

    core_mem_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_arb (
        .req   (REQ),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Byte-offset and upper address bits are deliberately dropped from the word index.
    assign unused_addr = ^ADDR;

    assign wait_load = 5'(BASE_WAIT) + 5'(EXTRA_WAIT);
    assign go_resp   = ((state == ST_IDLE) && (|REQ) && (wait_load == 5'd0)) ||
                       ((state == ST_WAIT) && (cnt == 5'd1));
    assign load_ok   = (state == ST_IDLE) && !(|REQ) && LOAD_EN;
    assign BUSY      = (state != ST_IDLE);
    assign ptr_next  = (t_port == PTR_W'(NUM_PORTS - 1)) ? '0 : t_port + PTR_W'(1);

    // A zero-wait grant responds on the same edge, so it works from the live request fields.
    always_comb begin
        if (state == ST_IDLE) begin
            t_grant = arb_grant;
            t_port  = arb_idx;
            t_we    = WE[arb_idx];
            t_idx   = ADDR[int'(arb_idx)*ADDR_W + OFF_W +: IDX_W];
            t_wdata = WDATA[int'(arb_idx)*DATA_W +: DATA_W];
            t_wstrb = WSTRB[int'(arb_idx)*STRB_W +: STRB_W];
        end else begin
            t_grant = cap_grant;
            t_port  = cap_port;
            t_we    = cap_we;
            t_idx   = cap_idx;
            t_wdata = cap_wdata;
            t_wstrb = cap_wstrb;
        end
        word = mem[t_idx];
        for (int b = 0; b < STRB_W; b++) begin
            if (t_we && t_wstrb[b]) begin
                word[b*8 +: 8] = t_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge CCLK) begin
        if (go_resp && t_we) begin
            mem[t_idx] <= word;
        end else if (load_ok) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            VALID     <= '0;
            RDATA     <= '0;
            cap_grant <= '0;
            cap_port  <= '0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
        end else begin
            VALID <= '0;
            case (state)
                ST_IDLE: begin
                    if (|REQ) begin
                        cap_grant <= t_grant;
                        cap_port  <= t_port;
                        cap_we    <= t_we;
                        cap_idx   <= t_idx;
                        cap_wdata <= t_wdata;
                        cap_wstrb <= t_wstrb;
                        cnt       <= wait_load;
                        state     <= (wait_load == 5'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= ST_RESP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (go_resp) begin
                VALID <= t_grant;
                RDATA <= word;
                ptr   <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_core_shared_mem.sv
// tb/tb_core_shared_mem.sv - randomized bench with a transaction-level memory model
module tb_core_shared_mem;

    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4096;
    localparam int BW    = 1;

    logic           CCLK, CRST;
    logic [NP-1:0]  REQ, WE;
    logic [NP*AW-1:0] ADDR;
    logic [NP*DW-1:0] WDATA;
    logic [NP*4-1:0]  WSTRB;
    logic [3:0]     EXTRA_WAIT;
    logic [DW-1:0]  RDATA;
    logic [NP-1:0]  VALID;
    logic           BUSY;
    logic           LOAD_EN;
    logic [11:0]    LOAD_ADDR;
    logic [DW-1:0]  LOAD_DATA;

    int total = 0;
    int bad   = 0;

    core_shared_mem #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_WAIT(BW)) dut (
        .CCLK(CCLK), .CRST(CRST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .WSTRB(WSTRB), .EXTRA_WAIT(EXTRA_WAIT), .RDATA(RDATA), .VALID(VALID), .BUSY(BUSY),
        .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant is stamped with the edge its response is due on.
    logic [31:0] mmem [DEPTH];
    int          edge_n = 0, m_idle_edge = 0, m_resp_edge = 0, m_port = 0, m_rr = 0;
    bit          m_flight = 0, m_we = 0, m_busy = 0, responded, found;
    logic [11:0] m_idx;
    logic [31:0] m_wdata, m_rdata = 0, w;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_valid = 0;
    int          p;

    always @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            m_flight = 0; m_rr = 0; m_valid = 0; m_rdata = 0; m_idle_edge = 0; m_busy = 0;
        end else begin
            edge_n++;
            m_valid   = 0;
            responded = 0;
            if (!m_flight && edge_n >= m_idle_edge && REQ != 0) begin
                found = 0;
                for (int k = 0; k < NP; k++) begin
                    p = (m_rr + k) % NP;
                    if (!found && REQ[p]) begin
                        found       = 1;
                        m_port      = p;
                        m_we        = WE[p];
                        m_idx       = 12'((ADDR[p*AW +: AW] / 4) % DEPTH);
                        m_wdata     = WDATA[p*DW +: DW];
                        m_wstrb     = WSTRB[p*4 +: 4];
                        m_resp_edge = edge_n + BW + int'(EXTRA_WAIT);
                        m_flight    = 1;
                    end
                end
            end else if (!m_flight && edge_n >= m_idle_edge && LOAD_EN) begin
                mmem[LOAD_ADDR] = LOAD_DATA;
            end
            if (m_flight && edge_n == m_resp_edge) begin
                w = mmem[m_idx];
                if (m_we) begin
                    for (int b = 0; b < 4; b++) if (m_wstrb[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
                    mmem[m_idx] = w;
                end
                m_rdata         = w;
                m_valid[m_port] = 1'b1;
                m_rr            = (m_port + 1) % NP;
                m_flight        = 0;
                m_idle_edge     = edge_n + 2;
                responded       = 1;
            end
            m_busy = m_flight || responded;
        end
    end

    always @(negedge CCLK) begin
        if (!CRST) begin
            chk("valid", VALID, m_valid);
            chk("busy", BUSY, m_busy);
            chk("rdata", RDATA, m_rdata);
        end
    end

    task automatic do_load(input logic [11:0] a, input logic [31:0] d);
        LOAD_EN = 1; LOAD_ADDR = a; LOAD_DATA = d;
        @(negedge CCLK);
        LOAD_EN = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CCLK);
        while (BUSY && n < 60) begin
            @(negedge CCLK);
            n++;
        end
        chk("idle_wait", BUSY, 0);
    endtask

    task automatic do_reset();
        @(negedge CCLK);
        CRST = 1; REQ = 0; LOAD_EN = 0;
        repeat (2) @(negedge CCLK);
        CRST = 0;
    endtask

    task automatic txn(input int port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [3:0] extra,
                       output int lat, output int busy_n, output logic [31:0] data);
        wait_idle();
        REQ = 0; REQ[port] = 1; WE[port] = we;
        ADDR[port*AW +: AW] = addr; WDATA[port*DW +: DW] = wdata; WSTRB[port*4 +: 4] = strb;
        EXTRA_WAIT = extra; LOAD_EN = 0;
        lat = 0; busy_n = 0; data = '0;
        while (lat < 40) begin
            @(negedge CCLK);
            lat++;
            if (lat == 1) EXTRA_WAIT = 0;
            if (BUSY) busy_n++;
            if (VALID[port]) begin
                data = RDATA;
                break;
            end
        end
        REQ = 0;
    endtask

    int          lat, bn;
    logic [31:0] d;
    int          seq[$];

    initial begin
        CRST = 1; REQ = 0; WE = 0; ADDR = 0; WDATA = 0; WSTRB = 0;
        EXTRA_WAIT = 0; LOAD_EN = 0; LOAD_ADDR = 0; LOAD_DATA = 0;
        repeat (3) @(negedge CCLK);
        chk("reset_valid", VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_rdata", RDATA, 0);
        CRST = 0;

        for (int i = 0; i < 16; i++) begin
            if (i == 0)      do_load(12'(i), 32'h0000_0013);
            else if (i == 1) do_load(12'(i), 32'h1122_3344);
            else if (i == 2) do_load(12'(i), 32'hCAFE_0002);
            else             do_load(12'(i), $urandom);
        end

        txn(0, 0, 32'd0, 0, 4'h0, 4'd0, lat, bn, d);
        chk("rd0_lat", lat, 2);
        chk("rd0_data", d, 32'h0000_0013);
        chk("rd0_busy_cycles", bn, 2);

        txn(1, 1, 32'd4, 32'hAABB_CCDD, 4'b0101, 4'd0, lat, bn, d);
        chk("wr_strb_data", d, 32'h11BB_33DD);
        txn(0, 0, 32'd4, 0, 4'h0, 4'd0, lat, bn, d);
        chk("wr_readback", d, 32'h11BB_33DD);

        txn(0, 0, 32'd0, 0, 4'h0, 4'd5, lat, bn, d);
        chk("extra_wait_lat", lat, 7);

        txn(1, 0, 32'(DEPTH*4 + 8), 0, 4'h0, 4'd0, lat, bn, d);
        chk("wrap_data", d, 32'hCAFE_0002);

        txn(1, 1, 32'd8, 32'h5555_5555, 4'b0000, 4'd0, lat, bn, d);
        chk("zero_strb_lat", lat, 2);
        chk("zero_strb_data", d, 32'hCAFE_0002);
        txn(0, 0, 32'd8, 0, 4'h0, 4'd0, lat, bn, d);
        chk("zero_strb_readback", d, 32'hCAFE_0002);

        wait_idle();
        REQ = 2'b01; WE = 0; ADDR[31:0] = 0; EXTRA_WAIT = 4'd5;
        repeat (2) @(negedge CCLK);
        EXTRA_WAIT = 0;
        #2 CRST = 1;
        #1;
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_valid", VALID, 0);
        REQ = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CCLK);
            chk("rst_hold_valid", VALID, 0);
        end
        CRST = 0;
        txn(0, 0, 32'd0, 0, 4'h0, 4'd0, lat, bn, d);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_data", d, 32'h0000_0013);

        do_reset();
        REQ = 2'b11; WE = 0; ADDR = {32'd4, 32'd0}; EXTRA_WAIT = 0;
        for (int i = 0; i < 80 && seq.size() < 4; i++) begin
            @(negedge CCLK);
            if (VALID != 0) seq.push_back(VALID[1] ? 1 : 0);
        end
        REQ = 0;
        chk("alt_count", seq.size(), 4);
        for (int i = 0; i < seq.size(); i++) chk("alt_order", seq[i], i % 2);

        for (int i = 0; i < 800; i++) begin
            @(negedge CCLK);
            REQ        = 2'($urandom);
            WE         = 2'($urandom);
            for (int q = 0; q < NP; q++)
                ADDR[q*AW +: AW] = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3) |
                                   ($urandom_range(0, 7) << 14);
            WDATA      = {$urandom, $urandom};
            WSTRB      = 8'($urandom);
            EXTRA_WAIT = 4'($urandom_range(0, 3));
            LOAD_EN    = ($urandom_range(0, 3) == 0);
            LOAD_ADDR  = 12'($urandom_range(0, 15));
            LOAD_DATA  = $urandom;
        end
        REQ = 0; LOAD_EN = 0;
        wait_idle();
        repeat (2) @(negedge CCLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/core_shared_mem.md
Name: core_shared_mem

Overview:
- Synthesizable, parametrised memory model in the core clock domain (CCLK) serving NUM_PORTS core-side request/response channels from one shared word-addressed RAM. Port 0 carries instruction fetch, port 1 data, higher ports are spare.
- Generalises the fixed two-memory arrangement used for core bring-up. Adds per-port arbitration, programmable wait-state injection, byte-enable writes, and a preload port, so no hierarchical RAM writes are needed.

Parameters:
- NUM_PORTS, 2, number of request channels (1..8).
- DATA_W, 32, data width in bits (multiple of 8).
- ADDR_W, 32, byte-address width per port.
- DEPTH, 4096, RAM depth in words (power of two).
- BASE_WAIT, 1, fixed wait cycles between grant and response (0..15).

Ports:
- CCLK  in  1  core clock
- CRST  in  1  asynchronous reset, active-high
- REQ  in  NUM_PORTS  per-port request strobe, held until VALID
- WE  in  NUM_PORTS  per-port write enable
- ADDR  in  NUM_PORTS*ADDR_W  packed byte addresses, port p at [p*ADDR_W +: ADDR_W]
- WDATA  in  NUM_PORTS*DATA_W  packed write data
- WSTRB  in  NUM_PORTS*DATA_W/8  packed byte strobes
- EXTRA_WAIT  in  4  runtime wait cycles added to BASE_WAIT, sampled at grant
- RDATA  out  DATA_W  read data; meaningful only with the VALID bit of the granted port
- VALID  out  NUM_PORTS  one-cycle response pulse per port
- BUSY  out  1  high whenever the FSM is not in IDLE
- LOAD_EN  in  1  preload write strobe
- LOAD_ADDR  in  clog2(DEPTH)  preload word index
- LOAD_DATA  in  DATA_W  preload data (full word)

Behaviour:
- Reset (CRST high, async): FSM returns to IDLE. VALID=0, BUSY=0, RDATA=0, round-robin pointer=0, wait counter=0. RAM contents are not cleared.
- Word index = ADDR[clog2(DATA_W/8) +: clog2(DEPTH)]. Upper address bits are ignored, so addresses wrap modulo DEPTH words. Low byte-offset bits are ignored.
- FSM states:
  - IDLE: if any REQ bit is high, grant the lowest-numbered requesting port at or after the RR pointer. Capture that port's WE, index, WDATA and WSTRB, plus EXTRA_WAIT. Load counter = BASE_WAIT+EXTRA_WAIT. Go to WAIT, or to RESP if the count is 0.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0 after the decrement.
  - RESP:
    - Write: update each byte whose captured WSTRB bit is set. RDATA holds the post-write word.
    - Read: RDATA = RAM[index].
    - Assert VALID[granted] for exactly this cycle. RR pointer = granted+1 mod NUM_PORTS. Return to IDLE.
- Latency: from the REQ-sampled edge to the VALID cycle = 1 + BASE_WAIT + EXTRA_WAIT cycles. With BASE_WAIT=0 and EXTRA_WAIT=0, VALID is high the cycle after REQ is sampled.
- Back-to-back: a REQ still high in the VALID cycle is not re-granted until the next IDLE cycle. At most one transaction is in flight.
- Requests are captured at grant. Deasserting REQ or changing ADDR afterwards does not cancel or alter the transaction.
- RDATA holds its value after VALID until the next RESP.
- LOAD_EN:
  - Honoured only in IDLE with no REQ bit high (bench preload window).
  - Writes LOAD_DATA to RAM[LOAD_ADDR] in one cycle.
  - If REQ is also high, the grant wins and the LOAD_EN write is dropped.
- WSTRB all zero on a write: no RAM change, and VALID is still issued.
- Reset mid-transaction: the transaction is lost and no VALID is issued. An in-progress RESP write may or may not have completed.

Decomposition:
- Package core_mem_pkg holds:
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP);
  - the width helper for the word index;
  - MAX_PORTS = 8.
- One sub-module: core_mem_rr_arbiter (NUM_PORTS request vector plus pointer in; one-hot grant plus encoded index out; purely combinational). The RAM array and FSM stay in core_shared_mem.

Test Plan:
- Preload RAM[0]=32'h0000_0013 via LOAD_EN. Port0 reads ADDR=0 with BASE_WAIT=1, EXTRA_WAIT=0. VALID[0] comes 2 cycles after REQ is sampled, RDATA=32'h0000_0013, BUSY high for 2 cycles.
- Port1 writes ADDR=4, WDATA=32'hAABBCCDD, WSTRB=4'b0101 over a preloaded 32'h11223344. The RESP cycle returns RDATA=32'h11BB33DD; a subsequent port0 read of ADDR=4 returns the same value.
- Port0 and port1 both hold REQ continuously after reset. Grants alternate 0,1,0,1; no port receives two consecutive VALIDs.
- EXTRA_WAIT=5, BASE_WAIT=1. VALID arrives 7 cycles after the REQ sample. Changing EXTRA_WAIT to 0 mid-WAIT does not shorten the latency.
- Read ADDR=DEPTH*4+8. RDATA equals RAM[2] (wrap-around).
- Assert CRST during WAIT of a port0 read. VALID stays 0 and BUSY drops asynchronously. After release, a new port0 request completes normally with its nominal latency.
